// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode/funct codes, producer latency classes and decode result type for the ID hazard unit.
package hazard_scoreboard_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_MUL   = 6'h02;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic is_br;
  } src_use_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard scoreboard bundle. HAZARD_PERF_EN adds the stall performance counters.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 3
) ();
  // id_valid/stall behave as valid/ready: the ID instruction issues on a cycle
  // where id_valid is high while stall, pipe_hold and id_flush are all low.
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_flush;
  logic              iss_we;
  logic [REG_AW-1:0] iss_dst;
  logic [CNT_W-1:0]  iss_lat;
  logic              pipe_hold;
  logic              stall;
  logic [CNT_W-1:0]  stall_cycles;
`ifdef HAZARD_PERF_EN
  logic [31:0]       perf_stall_cyc;
  logic [31:0]       perf_stall_evt;
`endif

  modport master (
    output id_valid, id_opcode, id_funct, id_rs, id_rt, id_flush,
    output iss_we, iss_dst, iss_lat, pipe_hold,
`ifdef HAZARD_PERF_EN
    input  perf_stall_cyc, perf_stall_evt,
`endif
    input  stall, stall_cycles
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_flush,
    input  iss_we, iss_dst, iss_lat, pipe_hold,
`ifdef HAZARD_PERF_EN
    output perf_stall_cyc, perf_stall_evt,
`endif
    output stall, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard_src_decode.sv
// Combinational source-operand decode: which of rs/rt the ID instruction reads, and whether it resolves in ID.
module hazard_src_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output src_use_t   uses
);

  always_comb begin
    uses = '0;
    case (opcode)
      OP_RTYPE: begin
        uses.use_rs = 1'b1;
        uses.use_rt = (funct != FUNCT_JR);
      end
      OP_LW: uses.use_rs = 1'b1;
      OP_SW: begin
        uses.use_rs = 1'b1;
        uses.use_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        uses.use_rs = 1'b1;
        uses.use_rt = 1'b1;
        uses.is_br  = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI: uses.use_rs = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard producing an exact ID-stage stall count.
// Optional HAZARD_PERF_EN adds stall cycle/event counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_LAT  = 3,
  parameter int BR_EXTRA = 1,
  parameter int CNT_W    = $clog2(MAX_LAT + BR_EXTRA + 1)
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  hif
);

  localparam logic [CNT_W-1:0] BR_C  = CNT_W'(BR_EXTRA);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LAT);

  // cnt[r]: cycles until r is readable by an ID-resolved branch; EX consumers need BR_EXTRA fewer.
  logic [CNT_W-1:0]  cnt [NUM_REGS];
  src_use_t          uses;
  logic [REG_AW-1:0] rs, rt, dst;
  logic [CNT_W-1:0]  need_rs, need_rt, need_max, lat_c, load_val;
  logic              stall, id_fire, load_en;

  function automatic logic [CNT_W-1:0] need_of(input logic [CNT_W-1:0] c, input logic br);
    if (br)           return c;
    else if (c > BR_C) return c - BR_C;
    else              return '0;
  endfunction

  hazard_src_decode u_decode (
    .opcode (hif.id_opcode),
    .funct  (hif.id_funct),
    .uses   (uses)
  );

  assign rs  = hif.id_rs;
  assign rt  = hif.id_rt;
  assign dst = hif.iss_dst;

  always_comb begin
    need_rs  = '0;
    need_rt  = '0;
    if (uses.use_rs && rs != '0) need_rs = need_of(cnt[rs], uses.is_br);
    if (uses.use_rt && rt != '0) need_rt = need_of(cnt[rt], uses.is_br);
    need_max = (need_rs > need_rt) ? need_rs : need_rt;
  end

  // Reset gates the output combinationally so the stall drops in the cycle reset rises.
  assign hif.stall_cycles = (hif.id_valid && !reset) ? need_max : '0;
  assign stall            = (hif.stall_cycles != '0);
  assign hif.stall        = stall;

  assign id_fire  = hif.id_valid & ~stall & ~hif.pipe_hold & ~hif.id_flush;
  assign lat_c    = (hif.iss_lat > MAX_C) ? MAX_C : hif.iss_lat;
  assign load_val = lat_c + BR_C;
  assign load_en  = id_fire & hif.iss_we & (dst != '0) & (load_val != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (!hif.pipe_hold) begin
      for (int r = 1; r < NUM_REGS; r++)
        if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      // Written after the ageing loop so the new producer overrides its decrement.
      if (load_en) cnt[dst] <= load_val;
    end
  end

`ifdef HAZARD_PERF_EN
  logic        stall_prev;
  logic [31:0] perf_cyc, perf_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_prev <= 1'b0;
      perf_cyc   <= '0;
      perf_evt   <= '0;
    end else begin
      stall_prev <= stall;
      if (stall && !hif.pipe_hold) perf_cyc <= perf_cyc + 32'd1;
      if (stall && !stall_prev)    perf_evt <= perf_evt + 32'd1;
    end
  end

  assign hif.perf_stall_cyc = perf_cyc;
  assign hif.perf_stall_evt = perf_evt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized traffic against a
// ready-time reference model. Define HAZARD_PERF_EN to also check the performance counters.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_LAT  = 3;
  localparam int BR_EXTRA = 1;
  localparam int CNT_W    = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hif ();

  hazard_scoreboard #(
    .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MAX_LAT(MAX_LAT), .BR_EXTRA(BR_EXTRA), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .hif   (hif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: ready time of each register in unheld-cycle ticks.
  int               tick = 0;
  int               rdy [NUM_REGS];
  logic [CNT_W-1:0] exp_q [$];
  int unsigned      exp_cyc = 0;
  int unsigned      exp_evt = 0;
  bit               prev_stall = 1'b0;

  function automatic void src_use(input logic [5:0] op, input logic [5:0] fn,
                                  output bit urs, output bit urt, output bit br);
    urs = 0; urt = 0; br = 0;
    if (op == OP_RTYPE) begin urs = 1; urt = (fn != FUNCT_JR); end
    else if (op == OP_LW) urs = 1;
    else if (op == OP_SW) begin urs = 1; urt = 1; end
    else if (op == OP_BEQ || op == OP_BNE) begin urs = 1; urt = 1; br = 1; end
    else if (op >= OP_ADDI && op <= OP_XORI) urs = 1;
  endfunction

  function automatic int model_need();
    bit urs, urt, br;
    int n, t;
    n = 0;
    if (rst || !hif.id_valid) return 0;
    src_use(hif.id_opcode, hif.id_funct, urs, urt, br);
    if (urs && hif.id_rs != 0) begin
      t = rdy[hif.id_rs] + (br ? BR_EXTRA : 0) - tick;
      if (t > n) n = t;
    end
    if (urt && hif.id_rt != 0) begin
      t = rdy[hif.id_rt] + (br ? BR_EXTRA : 0) - tick;
      if (t > n) n = t;
    end
    return n;
  endfunction

  // driver tasks
  task automatic drive(input bit v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input bit we,
                       input logic [4:0] dst, input logic [2:0] lat,
                       input bit fl = 1'b0, input bit hold = 1'b0);
    hif.id_valid  = v;
    hif.id_opcode = op;
    hif.id_funct  = fn;
    hif.id_rs     = rs;
    hif.id_rt     = rt;
    hif.iss_we    = we;
    hif.iss_dst   = dst;
    hif.iss_lat   = lat;
    hif.id_flush  = fl;
    hif.pipe_hold = hold;
    #4;
  endtask

  task automatic advance();
    int  need, l;
    bit  fire, s;
    need = model_need();
    s    = (need != 0);
    fire = hif.id_valid && !s && !hif.pipe_hold && !hif.id_flush;
    @(posedge clk);
    if (rst) begin
      foreach (rdy[r]) rdy[r] = 0;
      exp_cyc = 0; exp_evt = 0; prev_stall = 0;
    end else begin
      if (s && !hif.pipe_hold) exp_cyc++;
      if (s && !prev_stall) exp_evt++;
      prev_stall = s;
      if (!hif.pipe_hold) begin
        if (fire && hif.iss_we && hif.iss_dst != 0) begin
          l = (int'(hif.iss_lat) > MAX_LAT) ? MAX_LAT : int'(hif.iss_lat);
          if (l + BR_EXTRA != 0) rdy[hif.iss_dst] = tick + 1 + l;
        end
        tick++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(0, OP_RTYPE, FUNCT_ADDU, 0, 0, 0, 0, 0);
      advance();
    end
  endtask

  task automatic test_reset();
    drive(1, OP_BEQ, 6'h0, 8, 9, 0, 0, 0);
    n_cmp++;
    if (hif.stall_cycles !== '0 || hif.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: stall_cycles=%0d stall=%b, expected 0/0", hif.stall_cycles, hif.stall);
    end
    advance(); advance();
    rst = 1'b0;
    for (int r = 1; r < 32; r += 7) begin
      drive(1, OP_BEQ, 6'h0, 5'(r), 5'(r + 1), 0, 0, 0);
      n_cmp++;
      if (hif.stall_cycles !== '0 || hif.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_clear r%0d: stall_cycles=%0d stall=%b, expected 0", r, hif.stall_cycles, hif.stall);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    int e [2] = '{1, 0};
    drive(1, OP_LW, 6'h0, 1, 8, 1, 8, 3'(LAT_LOAD));
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, OP_RTYPE, FUNCT_ADDU, 8, 8, 1, 9, 3'(LAT_ALU));
      n_cmp++;
      if (hif.stall_cycles !== CNT_W'(e[i]) || hif.stall !== (e[i] != 0)) begin
        n_fail++;
        $display("FAIL load_use[%0d]: stall_cycles=%0d stall=%b, expected %0d", i, hif.stall_cycles, hif.stall, e[i]);
      end
      advance();
    end
    idle(5);
  endtask

  task automatic test_load_branch();
    int e [3] = '{2, 1, 0};
    drive(1, OP_LW, 6'h0, 1, 8, 1, 8, 3'(LAT_LOAD));
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_BEQ, 6'h0, 8, 0, 0, 0, 0);
      n_cmp++;
      if (hif.stall_cycles !== CNT_W'(e[i]) || hif.stall !== (e[i] != 0)) begin
        n_fail++;
        $display("FAIL load_branch[%0d]: stall_cycles=%0d stall=%b, expected %0d", i, hif.stall_cycles, hif.stall, e[i]);
      end
      advance();
    end
  endtask

  task automatic test_alu_consumers();
    int e [2] = '{1, 0};
    drive(1, OP_RTYPE, FUNCT_ADDU, 1, 2, 1, 5, 3'(LAT_ALU));
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, OP_BNE, 6'h0, 5, 6, 0, 0, 0);
      n_cmp++;
      if (hif.stall_cycles !== CNT_W'(e[i]) || hif.stall !== (e[i] != 0)) begin
        n_fail++;
        $display("FAIL alu_branch[%0d]: stall_cycles=%0d stall=%b, expected %0d", i, hif.stall_cycles, hif.stall, e[i]);
      end
      advance();
    end
    drive(1, OP_RTYPE, FUNCT_ADDU, 1, 2, 1, 5, 3'(LAT_ALU));
    advance();
    drive(1, OP_RTYPE, FUNCT_SUBU, 5, 1, 1, 7, 3'(LAT_ALU));
    n_cmp++;
    if (hif.stall_cycles !== '0 || hif.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_ex_fwd: stall_cycles=%0d stall=%b, expected 0", hif.stall_cycles, hif.stall);
    end
    advance();
    idle(5);
  endtask

  task automatic test_pipe_hold();
    int e [6] = '{3, 3, 3, 2, 1, 0};
    bit h [6] = '{1, 1, 0, 0, 0, 0};
    drive(1, OP_SPECIAL2, FUNCT_MUL, 1, 2, 1, 4, 3'(LAT_MUL));
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1, OP_RTYPE, FUNCT_ADDU, 4, 0, 1, 6, 3'(LAT_ALU), 1'b0, h[i]);
      n_cmp++;
      if (hif.stall_cycles !== CNT_W'(e[i]) || hif.stall !== (e[i] != 0)) begin
        n_fail++;
        $display("FAIL pipe_hold[%0d]: stall_cycles=%0d stall=%b, expected %0d", i, hif.stall_cycles, hif.stall, e[i]);
      end
      advance();
    end
    idle(5);
  endtask

  task automatic test_flush_r0_jr();
    drive(1, OP_LW, 6'h0, 1, 0, 1, 0, 3'(LAT_LOAD));
    advance();
    drive(1, OP_RTYPE, FUNCT_ADDU, 0, 0, 1, 10, 3'(LAT_ALU));
    n_cmp++;
    if (hif.stall_cycles !== '0) begin
      n_fail++;
      $display("FAIL r0_untracked: stall_cycles=%0d, expected 0", hif.stall_cycles);
    end
    advance();
    drive(1, OP_LW, 6'h0, 1, 3, 1, 3, 3'(LAT_LOAD), 1'b1);
    advance();
    drive(1, OP_BEQ, 6'h0, 3, 3, 0, 0, 0);
    n_cmp++;
    if (hif.stall_cycles !== '0) begin
      n_fail++;
      $display("FAIL flush_no_entry: stall_cycles=%0d, expected 0", hif.stall_cycles);
    end
    advance();
    drive(1, OP_LW, 6'h0, 1, 9, 1, 9, 3'(LAT_MUL));
    advance();
    drive(1, OP_LW, 6'h0, 1, 8, 1, 8, 3'(LAT_LOAD));
    advance();
    drive(1, OP_RTYPE, FUNCT_JR, 8, 9, 0, 0, 0);
    n_cmp++;
    if (hif.stall_cycles !== 3'd1 || hif.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL jr_rs_only: stall_cycles=%0d stall=%b, expected 1", hif.stall_cycles, hif.stall);
    end
    advance();
    idle(5);
  endtask

  task automatic test_reset_mid_stall();
    drive(1, OP_LW, 6'h0, 1, 8, 1, 8, 3'(LAT_LOAD));
    advance();
    drive(1, OP_BEQ, 6'h0, 8, 0, 0, 0, 0);
    n_cmp++;
    if (hif.stall_cycles !== 3'd2) begin
      n_fail++;
      $display("FAIL pre_reset: stall_cycles=%0d, expected 2", hif.stall_cycles);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (hif.stall_cycles !== '0 || hif.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_immediate: stall_cycles=%0d stall=%b, expected 0", hif.stall_cycles, hif.stall);
    end
    advance();
    rst = 1'b0;
    drive(1, OP_BEQ, 6'h0, 8, 0, 0, 0, 0);
    n_cmp++;
    if (hif.stall_cycles !== '0 || hif.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cleared: stall_cycles=%0d stall=%b, expected 0", hif.stall_cycles, hif.stall);
    end
    advance();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    drive(0, OP_RTYPE, FUNCT_ADDU, 0, 0, 0, 0, 0);
    advance();
    rst = 1'b0;
    test_load_branch();
    n_cmp++;
    if (hif.perf_stall_cyc !== 32'd2 || hif.perf_stall_evt !== 32'd1) begin
      n_fail++;
      $display("FAIL perf_branch: cyc=%0d evt=%0d, expected 2/1", hif.perf_stall_cyc, hif.perf_stall_evt);
    end
  endtask
`endif

  task automatic test_random();
    logic [5:0] op, fn;
    logic [CNT_W-1:0] e, got;
    for (int i = 0; i < 400; i++) begin
      fn = FUNCT_ADDU;
      case ($urandom_range(0, 7))
        0: op = OP_RTYPE;
        1: begin op = OP_RTYPE; fn = FUNCT_JR; end
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        5: op = OP_BNE;
        6: op = OP_ADDIU;
        default: begin op = OP_SPECIAL2; fn = FUNCT_MUL; end
      endcase
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) != 0, op, fn, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      exp_q.push_back(CNT_W'(model_need()));
      e   = exp_q.pop_front();
      got = hif.stall_cycles;
      n_cmp++;
      if (got !== e || hif.stall !== (e != 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: stall_cycles=%0d stall=%b, expected %0d", i, got, hif.stall, e);
      end
      advance();
      rst = 1'b0;
    end
`ifdef HAZARD_PERF_EN
    n_cmp++;
    if (hif.perf_stall_cyc !== exp_cyc || hif.perf_stall_evt !== exp_evt) begin
      n_fail++;
      $display("FAIL perf_random: cyc=%0d evt=%0d, expected %0d/%0d",
               hif.perf_stall_cyc, hif.perf_stall_evt, exp_cyc, exp_evt);
    end
`endif
  endtask

  initial begin
    foreach (rdy[r]) rdy[r] = 0;
    drive(0, OP_RTYPE, FUNCT_ADDU, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_load_branch();
    idle(5);
    test_alu_consumers();
    test_pipe_hold();
    test_flush_r0_jr();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    idle(5);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
